// File: rtl/read_level_detector.sv
// read_level_detector: slices distorted Q5.11 Vth into MLC levels, compares with the
// FIFO-aligned transmitted level, and accumulates per-frame cell/symbol/bit error counts.
module read_level_detector #(
  parameter logic signed [15:0] VREF1     = 16'sd2048,
  parameter logic signed [15:0] VREF2     = 16'sd5120,
  parameter logic signed [15:0] VREF3     = 16'sd8192,
  parameter logic        [31:0] FRAME_LEN = 32'd1024,
  parameter int                 FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sym_valid,
  input  logic [1:0]         sym_in,
  input  logic               volt_valid,
  input  logic signed [15:0] volt_in,
  output logic               det_valid,
  output logic [1:0]         det_sym,
  output logic               det_err,
  output logic [31:0]        cell_cnt,
  output logic [31:0]        sym_err_cnt,
  output logic [31:0]        bit_err_cnt,
  output logic               busy,
  output logic               done,
  output logic               fifo_ovf,
  output logic               fifo_udf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEPTH = 2 ** FIFO_AW;
  state_t state, nextState;
  logic [1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0] count;
  logic [31:0] issueCnt;
  logic s1Valid;
  logic [1:0] s1Lvl, s1Tx, level;
  logic fifoEmpty, fifoFull, inFrame, accept, push, retire, lastRetire;

  // Distance between Gray codes L0=11, L1=10, L2=00, L3=01
  function automatic logic [1:0] bitErrs(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[1] ^ a[0] ^ b[1] ^ b[0]};
  endfunction

  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign fifoEmpty  = count == '0;
  assign fifoFull   = count[FIFO_AW];
  assign inFrame    = state == RUN && !start && issueCnt < FRAME_LEN;
  assign accept     = volt_valid && inFrame && !fifoEmpty;
  assign push       = sym_valid && (!fifoFull || accept);
  assign retire     = s1Valid && state == RUN && !start;
  assign lastRetire = retire && cell_cnt == FRAME_LEN - 32'd1;
  assign level      = volt_in < VREF1 ? 2'd0 : volt_in < VREF2 ? 2'd1 : volt_in < VREF3 ? 2'd2 : 2'd3;
  assign busy       = state == RUN;
  assign done       = state == DONE;

  always_comb begin
    nextState = start ? RUN : lastRetire ? DONE : state;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= sym_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      issueCnt    <= '0;
      s1Valid     <= 1'b0;
      s1Lvl       <= '0;
      s1Tx        <= '0;
      det_valid   <= 1'b0;
      det_sym     <= '0;
      det_err     <= 1'b0;
      cell_cnt    <= '0;
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
      fifo_ovf    <= 1'b0;
      fifo_udf    <= 1'b0;
    end else begin
      state       <= nextState;
      wrPtr       <= wrPtr + {{(FIFO_AW-1){1'b0}}, push};
      rdPtr       <= rdPtr + {{(FIFO_AW-1){1'b0}}, accept};
      count       <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, accept};
      issueCnt    <= start ? '0 : issueCnt + {31'b0, accept};
      fifo_ovf    <= !start && (fifo_ovf || (sym_valid && fifoFull && !accept));
      fifo_udf    <= !start && (fifo_udf || (volt_valid && inFrame && fifoEmpty));
      s1Valid     <= accept;
      s1Lvl       <= accept ? level : s1Lvl;
      s1Tx        <= accept ? mem[rdPtr] : s1Tx;
      det_valid   <= retire;
      det_sym     <= retire ? s1Lvl : det_sym;
      det_err     <= retire ? s1Lvl != s1Tx : det_err;
      cell_cnt    <= start ? '0 : retire ? satAdd(cell_cnt, 2'd1) : cell_cnt;
      sym_err_cnt <= start ? '0 : retire ? satAdd(sym_err_cnt, {1'b0, s1Lvl != s1Tx}) : sym_err_cnt;
      bit_err_cnt <= start ? '0 : retire ? satAdd(bit_err_cnt, bitErrs(s1Tx, s1Lvl)) : bit_err_cnt;
    end
  end
endmodule
